// File: rtl/guess_reader.sv
// Hangman word reader: scans the stored word for a guessed letter, tracks revealed
// positions, requests a draw for each new reveal and reports the scan result.
module guess_reader #(
  parameter logic [7:0] X0     = 8'd100,
  parameter logic [7:0] SLOT_W = 8'd6,
  parameter logic [6:0] TEXT_Y = 7'd70
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       new_word,
  input  logic       start,
  input  logic [4:0] word_len,
  input  logic [4:0] guess,
  output logic [4:0] mem_addr,
  input  logic [4:0] mem_q,
  output logic       fill_valid,
  input  logic       fill_ready,
  output logic [4:0] fill_char,
  output logic [7:0] fill_x,
  output logic [6:0] fill_y,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [4:0] count,
  output logic [4:0] remain,
  output logic       solved
);

  typedef enum logic [2:0] {IDLE, READ, CMP, EMIT, NEXT, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  guess_q, guess_d;
  logic [4:0]  len_q, len_d;
  logic [31:1] mask_q, mask_d;
  logic        valid_q, valid_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  remain_q, remain_d;
  logic        match_q, match_d;
  logic [7:0]  slot_off;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      guess_q  <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      remain_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      len_q    <= len_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    len_d    = len_q;
    mask_d   = mask_q;
    valid_d  = valid_q;
    count_d  = count_q;
    remain_d = remain_q;
    match_d  = match_q;
    unique case (state_q)
      IDLE: begin
        if (new_word) begin
          mask_d   = '0;
          remain_d = word_len;
          valid_d  = 1'b1;
        end else if (start) begin
          guess_d = guess;
          len_d   = word_len;
          count_d = '0;
          match_d = 1'b0;
          idx_d   = 5'd1;
          state_d = (word_len == 5'd0) ? DONE : READ;
        end
      end
      READ: state_d = CMP;
      CMP: begin
        state_d = NEXT;
        if (mem_q == guess_q) begin
          match_d = 1'b1;
          if (!mask_q[idx_q]) begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + 5'd1;
            // Guard keeps remain at zero when scanning a word that was never loaded
            if (remain_q != 5'd0) remain_d = remain_q - 5'd1;
            state_d = EMIT;
          end
        end
      end
      EMIT: if (fill_ready) state_d = NEXT;
      NEXT: begin
        if (idx_q == len_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign slot_off   = {3'b000, idx_q - 5'd1};
  assign mem_addr   = idx_q;
  assign fill_valid = (state_q == EMIT);
  assign fill_char  = fill_valid ? guess_q : '0;
  assign fill_x     = fill_valid ? X0 + slot_off * SLOT_W : '0;
  assign fill_y     = fill_valid ? TEXT_Y : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign match      = match_q;
  assign count      = count_q;
  assign remain     = remain_q;
  assign solved     = valid_q & (remain_q == 5'd0);

endmodule

// File: doc/guess_reader.md
# guess_reader

Reader side of the hangman word memory. The datapath writes the secret word one 5-bit character per address, starting at address 1, into the 32x5 word RAM. This block reads the word back for each guess, compares every stored letter against the guessed character, and tracks which positions are already revealed. For each newly revealed letter it issues a draw request with pixel coordinates to the VGA fill logic, and at the end of the scan it reports match, count, remaining letters and solved status to the game FSM.

## Interface
Parameters:
- X0, 8'd100: x pixel of letter slot 1
- SLOT_W, 8'd6: x pixel pitch between letter slots
- TEXT_Y, 7'd70: y pixel of the letter row

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- new_word  in  1  pulse; clears revealed mask and loads remain from word_len (IDLE only)
- start  in  1  pulse; begins a scan for guess (IDLE only)
- word_len  in  5  stored word length; letters live at addresses 1..word_len
- guess  in  5  guessed character code (A=1 … Z=26), sampled on start
- mem_addr  out  5  word RAM read address
- mem_q  in  5  word RAM read data, valid exactly one cycle after mem_addr is presented
- fill_valid  out  1  draw request valid
- fill_ready  in  1  draw request accepted; transfer occurs when fill_valid & fill_ready at a clock edge
- fill_char  out  5  character to draw
- fill_x  out  8  X0 + (idx-1)*SLOT_W, modulo 256
- fill_y  out  7  TEXT_Y
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of scan
- match  out  1  guess occurs at least once in the word (registered, valid from done onward)
- count  out  5  number of newly revealed positions in the last scan
- remain  out  5  unrevealed letter count
- solved  out  1  word loaded and remain == 0

## Operation
- Internal state:
  - 31-bit revealed mask, one bit per address 1..31
  - word_valid flag
  - 5-bit idx
  - guess_r and len_r, latched on start
- States: IDLE, READ, CMP, EMIT, NEXT, DONE.
- **IDLE**
  - new_word clears the mask, sets remain = word_len and sets word_valid.
  - start latches guess and word_len, clears count and match, and sets idx = 1.
    - If word_len == 0, next state is DONE.
    - Otherwise, next state is READ.
  - new_word and start in the same cycle: new_word wins and start is dropped.
  - Both inputs are ignored in every state other than IDLE.
- **READ**: mem_addr = idx; go to CMP.
- **CMP**: compare mem_q to guess_r.
  - Equal and mask[idx] == 0: set mask[idx], count += 1, remain -= 1, match = 1, go to EMIT.
  - Equal and mask[idx] == 1: match = 1, go to NEXT.
  - Not equal: go to NEXT.
- **EMIT**
  - fill_valid = 1; fill_char = guess_r; fill_x and fill_y from idx.
  - All three fields are held stable until the transfer, then go to NEXT.
- **NEXT**: if idx == len_r go to DONE; otherwise idx += 1 and go to READ.
- **DONE**: done = 1 for one cycle; return to IDLE.
- match and count hold their values until the next start.
- remain never decrements below 0: a set mask bit blocks a second decrement.
- solved = word_valid & (remain == 0).
- Reset, including mid-scan: state goes to IDLE and everything is cleared, including the mask and word_valid.

## Timing
- Reset values:
  - mem_addr = 0, fill_valid = 0, fill_char = 0, fill_x = 0, fill_y = 0
  - busy = 0, done = 0, match = 0, count = 0, remain = 0, solved = 0
- start sampled at edge k: busy rises in cycle k+1.
- Each letter costs 3 cycles (READ, CMP, NEXT). Each new reveal adds EMIT cycles: 1 when fill_ready is held high, plus 1 per cycle of backpressure.
- done is high in cycle k+1+3L+E, where L = word_len and E = total EMIT cycles. With word_len == 0, done is high in cycle k+1.
- busy falls in the cycle after done.
- count and remain are updated at the CMP edge, so both are final when done is high.

## Test plan
- **Reset**: assert resetn low mid-scan → all outputs 0 and busy = 0; a subsequent start without new_word scans but solved stays 0.
- **Multi-match**: load HELLO (8, 5, 12, 12, 15) with word_len = 5, pulse new_word (remain = 5), start with guess = 12 and fill_ready = 1 → two transfers:
  - (12, 112, 70)
  - (12, 118, 70)
  - done in cycle k+18 with match = 1, count = 2, remain = 3.
- **Repeat guess**: guess = 12 again → no fill_valid; match = 1, count = 0, remain = 3.
- **Miss**: guess = 26 → match = 0, count = 0, done in cycle k+16; start pulsed while busy is ignored.
- **Backpressure**: guess = 8 with fill_ready low for 4 cycles → fill_valid and (8, 100, 70) held stable for 5 cycles; done is delayed by 4 cycles.
- **Solve and edge cases**:
  - Guesses 5 then 15 → remain = 0, solved = 1 after the final done.
  - word_len = 0 with start → done in cycle k+1, count = 0.
